sigma_delta_multichan: RTL and testbench

- NUM_CH-channel sine-wave generator. Each channel is a coupled-form digital resonator driving a first-order sigma-delta modulator with a 1-bit output.
- Generalises the two-piece sigma-delta generator in three ways:
  - parametrised channel count;
  - run-time per-channel frequency and amplitude loading over a valid/ready config port;
  - per-channel enable with clean seeding, plus an oscillator update prescaler.
- Sits between the control/register logic and the output pins or filters.

---
 rtl/sigma_delta_multichan.sv | 141 ++++++++++++++
 tb/tb_sigma_delta_multichan.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_multichan.sv
// Multi-channel sine generator: coupled-form resonator per channel feeding a 1st-order sigma-delta modulator.
// Latency: config takes effect 1 clk after transfer; sd_out is registered 1 clk after the resonator s value.
// Backpressure: cfg_ready drops on prescaler tick cycles; cfg_valid/word must be held until cfg_ready.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-low reset
//   cfg_valid/ready config handshake; transfer when both high
//   cfg_ch/en/k/amp target channel, run enable, frequency coefficient (Q0.KW), seed amplitude
//   sd_out          per-channel 1-bit sigma-delta stream
//   running         per-channel RUN flag
//   cfg_err         one-cycle pulse after a config to a channel index >= NUM_CH
//
// Note: with UPD_DIV = 1 every cycle is a tick, so cfg_ready is permanently 0 and
// channels cannot be configured at run time.
module sigma_delta_multichan #(
    parameter int NUM_CH   = 4,
    parameter int BITWIDTH = 40,
    parameter int KW       = 28,
    parameter int UPD_DIV  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [3:0]            cfg_ch,
    input  logic                  cfg_en,
    input  logic [KW-1:0]         cfg_k,
    input  logic [BITWIDTH-3:0]   cfg_amp,
    output logic [NUM_CH-1:0]     sd_out,
    output logic [NUM_CH-1:0]     running,
    output logic                  cfg_err
);

    typedef enum logic {OFF, RUN} state_t;

    localparam int CW = (UPD_DIV > 1) ? $clog2(UPD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(UPD_DIV - 1);
    localparam int PW = BITWIDTH + KW;
    // Modulator full scale, 2^(BITWIDTH-2), in the error-accumulator width.
    localparam logic signed [BITWIDTH+1:0] FS = {4'b0001, {(BITWIDTH-2){1'b0}}};

    logic [CW-1:0] cnt_q;
    logic          tick;
    logic          accept;
    logic          ch_ok;

    assign tick      = (cnt_q == CNT_LAST);
    // Ready is withheld on tick cycles so a config never lands on an oscillator update.
    assign cfg_ready = reset & ~tick;
    assign accept    = cfg_valid & cfg_ready;
    assign ch_ok     = ({1'b0, cfg_ch} < 5'(NUM_CH));

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            cfg_err <= 1'b0;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + CW'(1);
            cfg_err <= accept & ~ch_ok;
        end
    end

    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                      state_q, state_nxt;
        logic                        sel;
        logic                        sd_q;
        logic [KW-1:0]               k_q;
        logic signed [BITWIDTH-1:0]  c_q, s_q, c_nxt, s_nxt;
        logic signed [BITWIDTH+1:0]  e_q, v, e_nxt;
        logic                        bit_nxt;
        logic signed [PW-1:0]        k_x, s_x, c_x;

        assign sel        = accept & (cfg_ch == 4'(i));
        assign sd_out[i]  = sd_q;
        assign running[i] = (state_q == RUN);

        always_comb begin
            state_nxt = state_q;
            if (sel) begin
                state_nxt = cfg_en ? RUN : OFF;
            end
        end

        // Resonator and modulator datapath. s' uses the freshly computed c'
        // (the coupled form that keeps the amplitude stable).
        always_comb begin
            k_x     = $signed({{BITWIDTH{1'b0}}, k_q});
            s_x     = {{KW{s_q[BITWIDTH-1]}}, s_q};
            c_nxt   = c_q - BITWIDTH'((k_x * s_x) >>> KW);
            c_x     = {{KW{c_nxt[BITWIDTH-1]}}, c_nxt};
            s_nxt   = s_q + BITWIDTH'((k_x * c_x) >>> KW);
            v       = e_q + {{2{s_q[BITWIDTH-1]}}, s_q};
            bit_nxt = ~v[BITWIDTH+1];
            e_nxt   = bit_nxt ? (v - FS) : (v + FS);
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= OFF;
                k_q     <= '0;
                c_q     <= '0;
                s_q     <= '0;
                e_q     <= '0;
                sd_q    <= 1'b0;
            end else begin
                state_q <= state_nxt;
                if (sel) begin
                    if (!cfg_en) begin
                        c_q  <= '0;
                        s_q  <= '0;
                        e_q  <= '0;
                        sd_q <= 1'b0;
                    end else if (state_q == OFF) begin
                        k_q  <= cfg_k;
                        c_q  <= {{2{cfg_amp[BITWIDTH-3]}}, cfg_amp};
                        s_q  <= '0;
                        e_q  <= '0;
                        sd_q <= 1'b0;
                    end else begin
                        // Retune: only k changes so the phase carries on; tick
                        // cannot coincide with an accepted word.
                        k_q  <= cfg_k;
                        e_q  <= e_nxt;
                        sd_q <= bit_nxt;
                    end
                end else if (state_q == RUN) begin
                    e_q  <= e_nxt;
                    sd_q <= bit_nxt;
                    if (tick) begin
                        c_q <= c_nxt;
                        s_q <= s_nxt;
                    end
                end else begin
                    sd_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sigma_delta_multichan.sv
module tb_sigma_delta_multichan;

    localparam int NCH = 4;
    localparam int BW  = 40;
    localparam int KW  = 28;
    localparam int UD  = 4;
    localparam logic signed [BW+1:0] FS = 42'sd274877906944; // 2^38

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [3:0]      cfg_ch = 4'd0;
    logic            cfg_en = 1'b0;
    logic [KW-1:0]   cfg_k = '0;
    logic [BW-3:0]   cfg_amp = '0;
    logic [NCH-1:0]  sd_out;
    logic [NCH-1:0]  running;
    logic            cfg_err;

    always #5 clk = ~clk;

    sigma_delta_multichan #(.NUM_CH(NCH), .BITWIDTH(BW), .KW(KW), .UPD_DIV(UD)) dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_en(cfg_en), .cfg_k(cfg_k), .cfg_amp(cfg_amp),
        .sd_out(sd_out), .running(running), .cfg_err(cfg_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    endtask

    // ---------------- reference model (behavioural, from the equations) ----------------
    typedef struct packed {
        logic                 run;
        logic [KW-1:0]        k;
        logic signed [BW-1:0] c;
        logic signed [BW-1:0] s;
        logic signed [BW+1:0] e;
        logic                 sd;
    } ch_t;

    ch_t  m [NCH];
    int   m_cnt = 0;
    logic m_err = 1'b0;
    logic m_acc;
    assign m_acc = cfg_valid && reset && (m_cnt != UD - 1);

    function automatic logic signed [BW-1:0] mulsh(input logic [KW-1:0] k, input logic signed [BW-1:0] x);
        logic signed [BW+KW-1:0] p;
        p = $signed({{BW{1'b0}}, k}) * $signed({{KW{x[BW-1]}}, x});
        return p[BW+KW-1:KW];
    endfunction

    function automatic ch_t ch_next(input ch_t cur, input logic sel, input logic tick);
        ch_t n;
        logic signed [BW+1:0] v;
        logic signed [BW-1:0] c2;
        n = cur;
        v = cur.e + {{2{cur.s[BW-1]}}, cur.s};
        if (sel && !cfg_en) begin
            n.run = 1'b0; n.c = '0; n.s = '0; n.e = '0; n.sd = 1'b0;
        end else if (sel && !cur.run) begin
            n.run = 1'b1; n.k = cfg_k; n.c = {{2{cfg_amp[BW-3]}}, cfg_amp};
            n.s = '0; n.e = '0; n.sd = 1'b0;
        end else if (cur.run) begin
            if (sel) n.k = cfg_k;
            n.sd = (v >= 0);
            n.e  = n.sd ? v - FS : v + FS;
            if (tick) begin
                c2  = cur.c - mulsh(cur.k, cur.s);
                n.c = c2;
                n.s = cur.s + mulsh(cur.k, c2);
            end
        end else begin
            n.sd = 1'b0;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_cnt <= 0;
            m_err <= 1'b0;
            for (int i = 0; i < NCH; i++) m[i] <= '0;
        end else begin
            m_cnt <= (m_cnt == UD - 1) ? 0 : m_cnt + 1;
            m_err <= m_acc && (cfg_ch >= 4'(NCH));
            for (int i = 0; i < NCH; i++)
                m[i] <= ch_next(m[i], m_acc && (cfg_ch == 4'(i)), m_cnt == UD - 1);
        end
    end

    function automatic logic model_mismatch();
        logic bad;
        bad = (cfg_err !== m_err);
        for (int i = 0; i < NCH; i++)
            if (sd_out[i] !== m[i].sd || running[i] !== m[i].run) bad = 1'b1;
        return bad;
    endfunction

    int bx_n   = 0;
    int bx_bad = 0;
    always @(negedge clk) begin
        bx_n <= bx_n + 1;
        if (model_mismatch()) bx_bad <= bx_bad + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [3:0] ch, input logic en, input logic [KW-1:0] k, input logic [BW-3:0] amp);
        bit done;
        done = 1'b0;
        cfg_valid = 1'b1; cfg_ch = ch; cfg_en = en; cfg_k = k; cfg_amp = amp;
        for (int n = 0; n < 8 && !done; n++) begin
            #1;
            if (cfg_ready) done = 1'b1;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        if (!done) begin
            n_chk++;
            $display("FAIL send_timeout: ch %0d not accepted, got no ready expected ready within 8 clocks", ch);
        end
    endtask

    typedef struct {
        logic          vld;
        logic [3:0]    ch;
        logic          en;
        logic [KW-1:0] k;
        logic [BW-3:0] amp;
        logic          rdy;
        logic [3:0]    run;
        logic [3:0]    sd;
        logic          err;
    } vec_t;

    vec_t tbl [11];
    int   ones, pk, xfers;
    logic [3:0] err_chs [2];

    initial begin
        // k = 0 keeps s at 0, so each running channel's stream is a plain 1,0,1,0 toggle.
        tbl[0]  = '{1'b1, 4'd1, 1'b1, 28'd0, 38'h0040000000, 1'b1, 4'b0010, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'd0, 1'b0, 28'd0, 38'h0,          1'b1, 4'b0010, 4'b0010, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 1'b0, 28'd0, 38'h0,          1'b1, 4'b0010, 4'b0000, 1'b0};
        tbl[3]  = '{1'b1, 4'd2, 1'b1, 28'd0, 38'h0020000000, 1'b0, 4'b0010, 4'b0010, 1'b0};
        tbl[4]  = '{1'b1, 4'd2, 1'b1, 28'd0, 38'h0020000000, 1'b1, 4'b0110, 4'b0000, 1'b0};
        tbl[5]  = '{1'b1, 4'd7, 1'b1, 28'd0, 38'h0,          1'b1, 4'b0110, 4'b0110, 1'b1};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 28'd0, 38'h0,          1'b1, 4'b0110, 4'b0000, 1'b0};
        tbl[7]  = '{1'b0, 4'd0, 1'b0, 28'd0, 38'h0,          1'b0, 4'b0110, 4'b0110, 1'b0};
        tbl[8]  = '{1'b1, 4'd1, 1'b0, 28'd0, 38'h0,          1'b1, 4'b0100, 4'b0000, 1'b0};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 28'd0, 38'h0,          1'b1, 4'b0100, 4'b0100, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 28'd0, 38'h0,          1'b1, 4'b0100, 4'b0000, 1'b0};

        // Reset held for 10 clocks while a config word is offered.
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_en = 1'b1; cfg_k = 28'h0400000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_sd", sd_out, 0);
            check("rst_running", running, 0);
            check("rst_ready", cfg_ready, 0);
        end
        reset = 1'b1;

        // Directed table: cycle t starts with prescaler count t%4.
        for (int t = 0; t < 11; t++) begin
            cfg_valid = tbl[t].vld; cfg_ch = tbl[t].ch; cfg_en = tbl[t].en;
            cfg_k = tbl[t].k; cfg_amp = tbl[t].amp;
            #1;
            check($sformatf("tbl%0d_ready", t), cfg_ready, tbl[t].rdy);
            @(negedge clk);
            check($sformatf("tbl%0d_running", t), running, tbl[t].run);
            check($sformatf("tbl%0d_sd", t), sd_out, tbl[t].sd);
            check($sformatf("tbl%0d_err", t), cfg_err, tbl[t].err);
        end

        // Handshake: valid held 16 clocks from cycle 11; ready low only when count == 3.
        xfers = 0;
        cfg_valid = 1'b1; cfg_ch = 4'd3; cfg_en = 1'b1; cfg_k = '0; cfg_amp = '0;
        for (int i = 0; i < 16; i++) begin
            #1;
            check($sformatf("hs%0d_ready", i), cfg_ready, ((11 + i) % 4 != 3) ? 1 : 0);
            if (cfg_valid && cfg_ready) xfers++;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        check("hs_transfers", xfers, 12);
        check("hs_running3", running[3], 1);

        // Fresh start, then the frequency / density run.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send(4'd0, 1'b1, 28'h0400000, 38'h1000000000);
        check("ch0_running_after_load", running[0], 1);
        send(4'd2, 1'b1, 28'h0800000, 38'h0800000000);
        send(4'd1, 1'b1, 28'h0200000, 38'h0400000000);
        ones = 0; pk = 0;
        for (int j = 1; j <= 1608; j++) begin
            @(negedge clk);
            ones += int'(sd_out[0]);
            if (j >= 320 && j < 480) pk += int'(sd_out[0]);
        end
        check_rng("ch0_period_density", ones, 788, 820);
        check_rng("ch0_peak_density", pk, 97, 102);
        check("bitexact_after_freq", bx_bad, 0);

        // Phase-continuous retune to double the frequency.
        send(4'd0, 1'b1, 28'h0800000, 38'h0);
        ones = 0;
        for (int j = 0; j < 804; j++) begin
            @(negedge clk);
            ones += int'(sd_out[0]);
        end
        check_rng("ch0_retune_density", ones, 394, 410);
        check("bitexact_after_retune", bx_bad, 0);

        // Disable channel 2 while the others keep running.
        send(4'd2, 1'b0, 28'h0, 38'h0);
        check("ch2_off_running", running[2], 0);
        check("ch2_off_sd", sd_out[2], 0);
        repeat (200) @(negedge clk);
        check("bitexact_after_disable", bx_bad, 0);

        // Out-of-range channel indices: one-cycle error pulse, no state change.
        err_chs[0] = 4'd4; err_chs[1] = 4'd7;
        for (int i = 0; i < 2; i++) begin
            send(err_chs[i], 1'b0, 28'h0, 38'h0);
            check($sformatf("err_pulse_ch%0d", err_chs[i]), cfg_err, 1);
            check($sformatf("err_running_ch%0d", err_chs[i]), running, 4'b0011);
            @(negedge clk);
            check($sformatf("err_clear_ch%0d", err_chs[i]), cfg_err, 0);
        end
        check("bitexact_after_err", bx_bad, 0);
        check_rng("bitexact_cycles", bx_n, 2000, 100000);

        // Mid-run reset aborts everything at the next edge.
        cfg_valid = 1'b1; cfg_ch = 4'd3; cfg_en = 1'b1;
        reset = 1'b0;
        #1;
        check("midrst_ready", cfg_ready, 0);
        @(negedge clk);
        check("midrst_sd", sd_out, 0);
        check("midrst_running", running, 0);
        check("midrst_err", cfg_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
